muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU. The main decoder's multordiv/hlwrite/mvhl controls drive it.
- Supports mult, multu, div, divu, mthi, mtlo, mfhi and mflo at a parametrised data width.
- Multi-cycle operation; it raises a stall to the hazard unit while results are pending.

Parameters:
- WIDTH, 32: operand, HI and LO width (even, >=4).
- CNT_W, $clog2(WIDTH): iteration counter width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; from multordiv.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- a  in  WIDTH  rs operand (multiplicand/dividend).
- b  in  WIDTH  rt operand (multiplier/divisor).
- hlwrite  in  1  mthi/mtlo write strobe.
- hlsel  in  1  write target: 0 = LO, 1 = HI.
- wdata  in  WIDTH  mthi/mtlo data.
- rd_req  in  1  mfhi/mflo in EX.
- rsel  in  1  read select: 0 = LO, 1 = HI.
- rdata  out  WIDTH  combinational mux of HI/LO per rsel.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO just updated.
- stall  out  1  busy & (start | hlwrite | rd_req); combinational.

Behaviour:
- Reset (async, while reset = 0): state IDLE, HI = 0, LO = 0, counter 0, busy 0, done 0. Reset mid-operation aborts the operation; no HI/LO update.
- States:
  - IDLE -> RUN on start & !busy.
  - RUN: one bit per cycle, exactly WIDTH cycles.
  - FIX -> IDLE.
- Latency: start sampled at edge E0. busy is high for cycles E0+1 through E0+WIDTH+1. HI/LO are written at the edge ending FIX. done is high for the single following cycle, with busy low.
- Start while busy is ignored (stall holds the pipeline). hlwrite while busy is ignored.
- Start with hlwrite in the same idle cycle: the operation starts and the write is dropped.
- Start and done in the same cycle is legal; the new operation begins.
- Signed ops: operands are converted to magnitudes at start and sign-corrected in FIX.
- Multiply: 2*WIDTH-bit product; HI = upper half, LO = lower half.
- Divide: restoring algorithm. LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- Divide by zero (b = 0): LO = all ones, HI = a. This applies to both signed and unsigned; no trap. Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- rdata follows HI/LO immediately after the done edge. rd_req in the done cycle is not stalled.
- Idle mthi/mtlo: the selected register updates at the next edge; the other is unchanged.

Optional Feature:
- Macro: MULDIV_EARLY_DIVZERO_EN.
- Defined: a divide with b = 0 skips RUN and goes IDLE -> FIX. done follows 2 cycles after the start edge. Adds output divzero (1 bit), pulsed with that done.
- Undefined: a zero divisor runs the full WIDTH iterations; results are as above; no divzero port.

Decomposition:
- muldiv_pkg:
  - muldiv_op_t enum: MULT, MULTU, DIV, DIVU.
  - muldiv_state_t enum: IDLE, RUN, FIX.
  - op encoding localparams.
- One sub-module, muldiv_seq_core: shift/add-subtract datapath, counter and sign fixup, with a start/result-valid interface.
- The top level keeps HI/LO, the write port, the read mux and stall.

Test Plan:
- mult a = FFFFFFFF, b = 00000002 (WIDTH = 32) -> done at start + 34 cycles; HI = FFFFFFFF, LO = FFFFFFFE. multu with the same operands -> HI = 00000001, LO = FFFFFFFE.
- div a = FFFFFFF9 (-7), b = 2 -> LO = FFFFFFFD, HI = FFFFFFFF. divu a = 100, b = 7 -> LO = 0000000E, HI = 00000002.
- div a = 80000000, b = FFFFFFFF -> LO = 80000000, HI = 0. divu a = 5, b = 0 -> LO = FFFFFFFF, HI = 5.
  - MULDIV_EARLY_DIVZERO_EN defined: done at start + 2 cycles with divzero = 1.
- Issue mflo (rd_req, rsel = 0) during cycle 5 of RUN -> stall = 1 until done; rdata = new LO in the done cycle. mthi during busy -> ignored; HI keeps its multiply result.
- Idle mtlo wdata = 12345678, then mflo -> rdata = 12345678; HI unchanged.
- Drop reset mid-RUN after a prior result HI = 1, LO = 2 -> busy = 0, HI = LO = 0, no done pulse. Next start completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and state types shared by the multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    typedef enum logic [1:0] {MULT = OP_MULT, MULTU = OP_MULTU, DIV = OP_DIV, DIVU = OP_DIVU} muldiv_op_t;
    typedef enum logic [1:0] {IDLE, RUN, FIX} muldiv_state_t;
endpackage

// File: rtl/muldiv_seq_core.sv
// muldiv_seq_core: one-bit-per-cycle shift/add multiply and restoring divide with sign fixup
module muldiv_seq_core import muldiv_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_hi,
`ifdef MULDIV_EARLY_DIVZERO_EN
    output logic [WIDTH-1:0] res_lo,
    output logic             res_dz
`else
    output logic [WIDTH-1:0] res_lo
`endif
);
    muldiv_state_t state;
    muldiv_op_t o;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] ph, pl, m, ma_in, mb_in, nph, npl;
    logic [WIDTH:0] sum, t, diff;
    logic [2*WIDTH-1:0] prod;
    logic is_div, sgn, dz_in, div_m, neg_q, neg_r, dz;
    assign o      = muldiv_op_t'(op);
    assign is_div = (o == DIV) || (o == DIVU);
    assign sgn    = (o == MULT) || (o == DIV);
    assign dz_in  = is_div && (b == '0);
    assign ma_in  = (sgn && a[WIDTH-1]) ? -a : a;
    assign mb_in  = (sgn && b[WIDTH-1]) ? -b : b;
    // ph:pl is the product register when multiplying, remainder:quotient when dividing
    assign sum  = {1'b0, ph} + (pl[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    assign t    = {ph, pl[WIDTH-1]};
    assign diff = t - {1'b0, m};
    assign nph  = div_m ? (diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    assign npl  = div_m ? {pl[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], pl[WIDTH-1:1]};
    assign prod = neg_q ? -{ph, pl} : {ph, pl};
    // a zero divisor leaves the dividend magnitude in ph, so the remainder fixup yields a
    assign res_hi    = div_m ? (neg_r ? -ph : ph) : prod[2*WIDTH-1:WIDTH];
    assign res_lo    = div_m ? (dz ? '1 : (neg_q ? -pl : pl)) : prod[WIDTH-1:0];
    assign busy      = state != IDLE;
    assign res_valid = state == FIX;
`ifdef MULDIV_EARLY_DIVZERO_EN
    assign res_dz = res_valid && dz;
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            ph    <= '0;
            pl    <= '0;
            m     <= '0;
            div_m <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                cnt   <= '0;
                pl    <= is_div ? ma_in : mb_in;
                m     <= is_div ? mb_in : ma_in;
                div_m <= is_div;
                neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r <= sgn && a[WIDTH-1];
                dz    <= dz_in;
`ifdef MULDIV_EARLY_DIVZERO_EN
                state <= dz_in ? FIX : RUN;
                ph    <= dz_in ? ma_in : '0;
`else
                state <= RUN;
                ph    <= '0;
`endif
            end
        end else if (state == RUN) begin
            ph  <= nph;
            pl  <= npl;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end else begin
            state <= IDLE;
        end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO registers, mthi/mtlo/mfhi/mflo and stall around the iterative core; MULDIV_EARLY_DIVZERO_EN enables early divide-by-zero with divzero output
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hlwrite,
    input  logic             hlsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    input  logic             rsel,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_EARLY_DIVZERO_EN
    output logic             stall,
    output logic             divzero
`else
    output logic             stall
`endif
);
    logic res_valid;
    logic [WIDTH-1:0] res_hi, res_lo, hi, lo;
`ifdef MULDIV_EARLY_DIVZERO_EN
    logic res_dz;
`endif
    muldiv_seq_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) core (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .res_valid(res_valid),
        .res_hi(res_hi),
`ifdef MULDIV_EARLY_DIVZERO_EN
        .res_lo(res_lo),
        .res_dz(res_dz)
`else
        .res_lo(res_lo)
`endif
    );
    assign rdata = rsel ? hi : lo;
    assign stall = busy && (start || hlwrite || rd_req);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= res_valid;
            if (res_valid) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (hlwrite && !busy && !start) begin
                if (hlsel) hi <= wdata;
                else lo <= wdata;
            end
        end
`ifdef MULDIV_EARLY_DIVZERO_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) divzero <= 1'b0;
        else divzero <= res_dz;
`endif
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
`ifdef MULDIV_EARLY_DIVZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    typedef struct {logic [31:0] hi; logic [31:0] lo; int due; bit dz;} exp_t;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, hlwrite = 1'b0, hlsel = 1'b0, rd_req = 1'b0, rsel = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0, rdata, mhi = '0, mlo = '0;
    logic busy, done, stall;
`ifdef MULDIV_EARLY_DIVZERO_EN
    logic divzero;
`endif
    int nchk = 0, errs = 0, cyc = 0;
    exp_t sb[$];
    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hlwrite(hlwrite), .hlsel(hlsel), .wdata(wdata), .rd_req(rd_req), .rsel(rsel),
        .rdata(rdata), .busy(busy), .done(done),
`ifdef MULDIV_EARLY_DIVZERO_EN
        .stall(stall), .divzero(divzero)
`else
        .stall(stall)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic void model(input logic [1:0] o, input logic [31:0] x, y, output logic [31:0] hi, lo);
        longint p;
        int nx, ny;
        hi = '0;
        lo = '0;
        if (o == 2'd0) begin
            p = longint'($signed(x)) * longint'($signed(y));
            {hi, lo} = p;
        end else if (o == 2'd1) begin
            {hi, lo} = {32'b0, x} * {32'b0, y};
        end else if (y == 0) begin
            lo = '1;
            hi = x;
        end else if (o == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = '0;
        end else if (o == 2'd2) begin
            nx = x;
            ny = y;
            lo = nx / ny;
            hi = nx % ny;
        end else begin
            lo = x / y;
            hi = x % y;
        end
    endfunction
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic issue(input logic [1:0] o, input logic [31:0] x, y);
        exp_t e;
        logic [31:0] h, l;
        model(o, x, y, h, l);
        e.hi = h;
        e.lo = l;
        e.dz = o[1] && (y == 0);
        e.due = cyc + ((EARLY && e.dz) ? 2 : 34);
        sb.push_back(e);
        mhi = h;
        mlo = l;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        step();
        start = 1'b0;
    endtask
    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask
    // monitor: every done pulse must match the oldest outstanding operation
    always @(negedge clk) if (reset && done) begin
        exp_t e;
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.due);
            chk("busy_at_done", {31'b0, busy}, 32'd0);
            chk("rdata_at_done", rdata, rsel ? e.hi : e.lo);
            chk("hi", dut.hi, e.hi);
            chk("lo", dut.lo, e.lo);
`ifdef MULDIV_EARLY_DIVZERO_EN
            chk("divzero", {31'b0, divzero}, {31'b0, e.dz});
`endif
        end
    end
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        int n;
        logic [1:0] o;
        logic [31:0] x, y;
        #1 reset = 1'b0;
        repeat (2) step();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_lo", rdata, 32'd0);
        rsel = 1'b1;
        #1 chk("rst_hi", rdata, 32'd0);
        rsel = 1'b0;
        reset = 1'b1;
        step();
        issue(2'd0, 32'hFFFF_FFFF, 32'h2);        wait_done();
        issue(2'd1, 32'hFFFF_FFFF, 32'h2);        wait_done();
        issue(2'd2, 32'hFFFF_FFF9, 32'h2);        wait_done();
        issue(2'd3, 32'd100, 32'd7);              wait_done();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        issue(2'd3, 32'd5, 32'd0);                wait_done();
        issue(2'd2, 32'hFFFF_FF00, 32'd0);        wait_done();
        // mflo, mthi and a second start all arrive while busy
        issue(2'd0, 32'd3, 32'd5);
        repeat (3) step();
        rd_req = 1'b1;
        hlwrite = 1'b1;
        hlsel = 1'b1;
        wdata = 32'hDEAD_BEEF;
        start = 1'b1;
        op = 2'd3;
        a = 32'd1;
        b = 32'd1;
        #1 chk("stall_busy", {31'b0, stall}, 32'd1);
        step();
        start = 1'b0;
        hlwrite = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            chk("stall_rd", {31'b0, stall}, 32'd1);
            step();
            n++;
        end
        chk("stall_at_done", {31'b0, stall}, 32'd0);
        chk("mflo_at_done", rdata, 32'd15);
        rd_req = 1'b0;
        rsel = 1'b1;
        #1 chk("mthi_busy_ignored", rdata, 32'd0);
        rsel = 1'b0;
        step();
        hlwrite = 1'b1;
        hlsel = 1'b0;
        wdata = 32'h1234_5678;
        step();
        hlwrite = 1'b0;
        mlo = 32'h1234_5678;
        #1 chk("mtlo", rdata, 32'h1234_5678);
        rsel = 1'b1;
        #1 chk("mtlo_hi_kept", rdata, mhi);
        rsel = 1'b0;
        hlwrite = 1'b1;
        wdata = 32'hAAAA_AAAA;
        issue(2'd1, 32'd7, 32'd9);
        hlwrite = 1'b0;
        #1 chk("start_drops_write", rdata, 32'h1234_5678);
        wait_done();
        issue(2'd1, 32'h8000_0001, 32'd2);        wait_done();
        issue(2'd0, 32'd123, 32'd456);
        repeat (8) step();
        reset = 1'b0;
        sb.delete();
        #1 chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_lo", rdata, 32'd0);
        rsel = 1'b1;
        #1 chk("abort_hi", rdata, 32'd0);
        rsel = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (40) step();
        issue(2'd0, 32'hFFFF_FFFD, 32'd7);        wait_done();
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 5) == 0) y = '0;
            else if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) y = '1;
            issue(o, x, y);
            wait_done();
        end
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
